// File: rtl/nexys4_irq_arbiter_pkg.sv
// Shared types and constants for the PicoBlaze interrupt arbiter:
// FSM states, port-decode bits and cause-byte layout.
package nexys4_irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam int EOI_PORT_BIT  = 4;
  localparam int MASK_PORT_BIT = 5;

  localparam int CAUSE_INSVC   = 7;
  localparam int CAUSE_TMO     = 6;
  localparam int CAUSE_IDX_MSB = 2;
  localparam int IDX_W         = CAUSE_IDX_MSB + 1;

  // Round-robin successor of a source index; always 0 when there is one source.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int num_src);
    if (int'(idx) >= num_src - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/nexys4_irq_arbiter_if.sv
// Bundle between the event sources / PicoBlaze I/O bus and the interrupt arbiter.
// master = PicoBlaze side and sources, slave = arbiter.
interface nexys4_irq_arbiter_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0] src_in;
  logic               write_strobe;
  logic [7:0]         port_id;
  logic [7:0]         io_data_in;
  logic               interrupt_ack;
  logic               interrupt_request;
  logic [7:0]         irq_cause;
  logic [NUM_SRC-1:0] irq_pending;

  modport master (
    output src_in, write_strobe, port_id, io_data_in, interrupt_ack,
    input  interrupt_request, irq_cause, irq_pending
  );

  modport slave (
    input  src_in, write_strobe, port_id, io_data_in, interrupt_ack,
    output interrupt_request, irq_cause, irq_pending
  );
endinterface

// File: rtl/nexys4_irq_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
// Zero latency; vld_o low when no request is set.
module nexys4_rr_picker
  import nexys4_irq_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               vld_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic found;

  always_comb begin
    int t;
    t     = 0;
    found = 1'b0;
    idx_o = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      t = int'(ptr_i) + k;
      if (t >= NUM_SRC) t = t - NUM_SRC;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!found && req_i[i] && (t == i)) begin
          found = 1'b1;
          idx_o = IDX_W'(i);
        end
      end
    end
  end

  assign vld_o = found;

endmodule

// File: rtl/nexys4_irq_arbiter.sv
// Shares the PicoBlaze interrupt among NUM_SRC edge-triggered sources, round-robin,
// request held until ack, grant held until EOI; all outputs come straight from flops.
module nexys4_irq_arbiter
  import nexys4_irq_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 sysclk,
  input  logic                 sysreset,
  nexys4_irq_arbiter_if.slave  bus
);

  localparam logic [7:0] CNT_MAX = 8'(ACK_TIMEOUT);

  irq_state_e          state_q;
  logic [NUM_SRC-1:0]  src_q;
  logic [NUM_SRC-1:0]  pending_q;
  logic [NUM_SRC-1:0]  pending_d;
  logic [NUM_SRC-1:0]  mask_q;
  logic [IDX_W-1:0]    grant_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic                timeout_q;
  logic [7:0]          cnt_q;
  logic                req_q;
  logic                insvc_q;

  logic [NUM_SRC-1:0]  rise;
  logic [NUM_SRC-1:0]  grant_oh;
  logic                mask_wr;
  logic                eoi_wr;
  logic                eoi_ok;
  logic                pick_vld;
  logic [IDX_W-1:0]    pick_idx;
  logic [7:0]          cause;
  logic                unused_bits;

  assign rise    = bus.src_in & ~src_q;
  assign mask_wr = bus.write_strobe & bus.port_id[MASK_PORT_BIT];
  assign eoi_wr  = bus.write_strobe & bus.port_id[EOI_PORT_BIT];
  assign eoi_ok  = eoi_wr && (state_q == SERVICE);

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) grant_oh[i] = (grant_q == IDX_W'(i));
  end

  // A fresh edge on the granted source wins over its EOI clear.
  assign pending_d = (pending_q & ~(grant_oh & {NUM_SRC{eoi_ok}})) | rise;

  nexys4_rr_picker #(
    .NUM_SRC (NUM_SRC)
  ) u_picker (
    .req_i (pending_q & mask_q),
    .ptr_i (rr_ptr_q),
    .vld_o (pick_vld),
    .idx_o (pick_idx)
  );

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      state_q   <= IDLE;
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      insvc_q   <= 1'b0;
    end else begin
      src_q     <= bus.src_in;
      pending_q <= pending_d;
      if (mask_wr) mask_q <= bus.io_data_in[NUM_SRC-1:0];
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_idx;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (bus.interrupt_ack) begin
            req_q   <= 1'b0;
            insvc_q <= 1'b1;
            state_q <= SERVICE;
          end else if (cnt_q == CNT_MAX) begin
            req_q     <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        SERVICE: begin
          if (eoi_wr) begin
            rr_ptr_q  <= rr_next(grant_q, NUM_SRC);
            timeout_q <= 1'b0;
            insvc_q   <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          insvc_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    cause                    = '0;
    cause[CAUSE_INSVC]       = insvc_q;
    cause[CAUSE_TMO]         = timeout_q;
    cause[CAUSE_IDX_MSB:0]   = grant_q;
  end

  assign bus.interrupt_request = req_q;
  assign bus.irq_cause         = cause;
  assign bus.irq_pending       = pending_q;

  // Only two port_id bits are decoded and only NUM_SRC data bits feed the mask.
  assign unused_bits = ^{bus.port_id, bus.io_data_in};

endmodule

// File: tb/tb_nexys4_irq_arbiter.sv
// Scoreboard bench for nexys4_irq_arbiter: stimulus queues the expected output
// changes, a negedge monitor compares each observed change of {request, cause, pending}.
module tb_nexys4_irq_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  nexys4_irq_arbiter_if #(.NUM_SRC(4)) bus ();

  nexys4_irq_arbiter #(
    .NUM_SRC     (4),
    .ACK_TIMEOUT (8)
  ) dut (
    .sysclk   (clk),
    .sysreset (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       req;
    logic [7:0] cause;
    logic [3:0] pend;
    int         cy;
    int         id;
  } ev_t;

  ev_t  exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   ev_id    = 0;

  logic [12:0] mon_prev;
  logic [12:0] mon_cur;
  bit          mon_first = 1'b1;
  ev_t         mon_e;

  // Monitor: every change of the observable tuple must match the next queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      mon_cur = {bus.interrupt_request, bus.irq_cause, bus.irq_pending};
      if (mon_first || (mon_cur !== mon_prev)) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d: got req=%0b cause=%h pend=%b, want no change",
                   cyc, mon_cur[12], mon_cur[11:4], mon_cur[3:0]);
        end else begin
          mon_e = exp_q.pop_front();
          if ((mon_cur !== {mon_e.req, mon_e.cause, mon_e.pend}) ||
              ((mon_e.cy >= 0) && (mon_e.cy != cyc))) begin
            failures++;
            $display("FAIL ev%0d: got req=%0b cause=%h pend=%b cyc=%0d, want req=%0b cause=%h pend=%b cyc=%0d",
                     mon_e.id, mon_cur[12], mon_cur[11:4], mon_cur[3:0], cyc,
                     mon_e.req, mon_e.cause, mon_e.pend, mon_e.cy);
          end
        end
      end
      mon_prev  = mon_cur;
      mon_first = 1'b0;
    end
  end

  task automatic push(input logic r, input logic [7:0] c, input logic [3:0] p, input int cy);
    ev_t e;
    e.req   = r;
    e.cause = c;
    e.pend  = p;
    e.cy    = cy;
    e.id    = ev_id;
    ev_id++;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] port, input logic [7:0] data);
    bus.write_strobe = 1'b1;
    bus.port_id      = port;
    bus.io_data_in   = data;
    tick();
    bus.write_strobe = 1'b0;
    bus.port_id      = 8'h00;
    bus.io_data_in   = 8'h00;
  endtask

  // Reset pulse between scenarios; ev says whether the outputs are expected to change.
  task automatic rst_pulse(input bit ev);
    rst_n = 1'b0;
    if (ev) push(1'b0, 8'h00, 4'b0000, cyc);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Called with the DUT in REQ for source idx: ack, optional edge during service,
  // EOI (optionally colliding with a new edge), then optional re-request.
  task automatic serve(input logic [2:0] idx, input logic tmo, input logic [3:0] pend_svc,
                       input logic [3:0] edge_svc, input logic [3:0] edge_eoi,
                       input logic [3:0] pend_after, input bit next_req,
                       input logic [2:0] next_idx);
    int a;
    int e;
    logic [7:0] svc_cause;
    a         = cyc;
    svc_cause = {1'b1, tmo, 3'b000, idx};
    bus.interrupt_ack = 1'b1;
    push(1'b0, svc_cause, pend_svc, a + 1);
    tick();
    bus.interrupt_ack = 1'b0;
    if (edge_svc != 4'b0000) begin
      bus.src_in = edge_svc;
      push(1'b0, svc_cause, pend_svc | edge_svc, a + 2);
    end
    tick();
    bus.src_in = 4'b0000;
    tick();
    e = cyc;
    push(1'b0, {5'b00000, idx}, pend_after, e + 1);
    if (next_req) push(1'b1, {5'b00000, next_idx}, pend_after, e + 2);
    bus.src_in = edge_eoi;
    bus.write_strobe = 1'b1;
    bus.port_id      = 8'h10;
    bus.io_data_in   = 8'hA5;
    tick();
    bus.write_strobe = 1'b0;
    bus.port_id      = 8'h00;
    bus.io_data_in   = 8'h00;
    bus.src_in       = 4'b0000;
    tick();
  endtask

  initial begin
    int n;
    bus.src_in        = 4'b0000;
    bus.write_strobe  = 1'b0;
    bus.port_id       = 8'h00;
    bus.io_data_in    = 8'h00;
    bus.interrupt_ack = 1'b0;
    push(1'b0, 8'h00, 4'b0000, -1);
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single source: request two cycles after the edge, ack three cycles later.
    wr(8'h20, 8'h01);
    tick();
    n = cyc;
    bus.src_in = 4'b0001;
    push(1'b0, 8'h00, 4'b0001, n + 1);
    push(1'b1, 8'h00, 4'b0001, n + 2);
    tick();
    bus.src_in = 4'b0000;
    repeat (4) tick();
    serve(3'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0);

    // Round-robin over all four, with src0 re-firing while src1 is in service.
    rst_pulse(1'b0);
    wr(8'h20, 8'h0F);
    n = cyc;
    bus.src_in = 4'b1111;
    push(1'b0, 8'h00, 4'b1111, n + 1);
    push(1'b1, 8'h00, 4'b1111, n + 2);
    tick();
    bus.src_in = 4'b0000;
    tick();
    serve(3'd0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1110, 1'b1, 3'd1);
    serve(3'd1, 1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b1101, 1'b1, 3'd2);
    serve(3'd2, 1'b0, 4'b1101, 4'b0000, 4'b0000, 4'b1001, 1'b1, 3'd3);
    serve(3'd3, 1'b0, 4'b1001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 3'd0);
    serve(3'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0);

    // Masked source: captured as pending, requested only once enabled.
    rst_pulse(1'b0);
    n = cyc;
    bus.src_in = 4'b0100;
    push(1'b0, 8'h00, 4'b0100, n + 1);
    tick();
    bus.src_in = 4'b0000;
    repeat (5) tick();
    push(1'b1, 8'h02, 4'b0100, cyc + 2);
    wr(8'h20, 8'h04);
    tick();
    serve(3'd2, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0);

    // Timeout: nine REQ cycles without ack, sticky bit, same source re-requested.
    rst_pulse(1'b1);
    wr(8'h20, 8'h02);
    n = cyc;
    bus.src_in = 4'b0010;
    push(1'b0, 8'h00, 4'b0010, n + 1);
    push(1'b1, 8'h01, 4'b0010, n + 2);
    push(1'b0, 8'h41, 4'b0010, n + 11);
    push(1'b1, 8'h41, 4'b0010, n + 12);
    tick();
    bus.src_in = 4'b0000;
    repeat (11) tick();
    serve(3'd1, 1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0);

    // Collisions: EOI in REQ ignored, EOI together with a new edge re-arms the source.
    rst_pulse(1'b1);
    wr(8'h20, 8'h02);
    n = cyc;
    bus.src_in = 4'b0010;
    push(1'b0, 8'h00, 4'b0010, n + 1);
    push(1'b1, 8'h01, 4'b0010, n + 2);
    tick();
    bus.src_in = 4'b0000;
    tick();
    wr(8'h10, 8'h00);
    serve(3'd1, 1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 1'b1, 3'd1);
    serve(3'd1, 1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0);
    // Combined 0x30 write in IDLE: mask cleared, EOI ignored.
    wr(8'h30, 8'h00);
    n = cyc;
    bus.src_in = 4'b0010;
    push(1'b0, 8'h01, 4'b0010, n + 1);
    tick();
    bus.src_in = 4'b0000;
    repeat (5) tick();

    // Async reset in SERVICE, then mask must be back to zero.
    rst_pulse(1'b1);
    wr(8'h20, 8'h01);
    n = cyc;
    bus.src_in = 4'b0001;
    push(1'b0, 8'h00, 4'b0001, n + 1);
    push(1'b1, 8'h00, 4'b0001, n + 2);
    tick();
    bus.src_in = 4'b0000;
    tick();
    bus.interrupt_ack = 1'b1;
    push(1'b0, 8'h80, 4'b0001, n + 3);
    tick();
    bus.interrupt_ack = 1'b0;
    tick();
    #1;
    rst_n = 1'b0;
    push(1'b0, 8'h00, 4'b0000, cyc);
    tick();
    rst_n = 1'b1;
    tick();
    n = cyc;
    bus.src_in = 4'b0001;
    push(1'b0, 8'h00, 4'b0001, n + 1);
    tick();
    bus.src_in = 4'b0000;
    repeat (6) tick();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: got %0d outstanding, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nexys4_irq_arbiter.md
# nexys4_irq_arbiter

Shares the single PicoBlaze interrupt among up to eight event sources, such as the debounced-button change, a timer tick and switch change. It sits between the sources and the `interrupt_request` input of `nexys4_if`. The block latches rising-edge events as pending and picks one enabled source in round-robin order. It then drives the request until the PicoBlaze acknowledges and holds the grant in service until software writes end-of-interrupt (EOI). Software reads the cause byte through `nexys4_if` PORT_D (input port 0x03).

## Interface
- `NUM_SRC`, default 4: number of sources, legal range 1..8.
- `ACK_TIMEOUT`, default 255: cycles in REQ without `interrupt_ack` before the request is abandoned; legal range 1..255.

- `sysclk` in 1: system clock.
- `sysreset` in 1: reset, asynchronous, active-low.
- `src_in` in NUM_SRC: event sources, synchronous to `sysclk`; an event is a rising edge.
- `write_strobe` in 1: PicoBlaze write strobe.
- `port_id` in 8: PicoBlaze port address.
- `io_data_in` in 8: PicoBlaze output data.
- `interrupt_ack` in 1: PicoBlaze interrupt acknowledge.
- `interrupt_request` out 1: drives `nexys4_if.interrupt_request`.
- `irq_cause` out 8: cause byte, wired to `nexys4_if.PORT_D`.
- `irq_pending` out NUM_SRC: pending vector, for debug and LEDs.

## Operation
- **Edge detect:** `src_q <= src_in`. `pending[i]` is set on any cycle where `src_in[i] & ~src_q[i]`. Events are captured regardless of the mask.
- **Mask register:** a write with `write_strobe=1` and `port_id[5]=1` (port 0x20) loads `mask <= io_data_in[NUM_SRC-1:0]`. A mask bit of 1 enables the source. Reset value is all 0.
- **EOI:** a write with `write_strobe=1` and `port_id[4]=1` (port 0x10) ends service. The write data is ignored. EOI is honoured only in SERVICE and is ignored in every other state.
- **Port decode:** port decoding is one-hot. A single write may hit both 0x10 and 0x20 and performs both actions.
- **State machine:**
  - IDLE: when `pending & mask` ≠ 0, latch `grant` = first enabled pending index at or above `rr_ptr`, wrapping modulo NUM_SRC, and go to REQ.
  - REQ: `interrupt_request=1`. On `interrupt_ack=1`, go to SERVICE. When the cycle counter reaches ACK_TIMEOUT, go to IDLE and set sticky `timeout`; `pending` and `rr_ptr` are unchanged.
  - SERVICE: `interrupt_request=0`. On EOI: clear `pending[grant]`, set `rr_ptr <= (grant+1) mod NUM_SRC`, clear `timeout`, and go to IDLE.
- **Cause byte:**
  - bit7: in service (state is SERVICE).
  - bit6: timeout sticky.
  - bits5:3: always 0.
  - bits2:0: `grant`.
- **Boundary conditions:**
  - A new edge on `grant` in the same cycle as its EOI leaves `pending[grant]` set (set wins), so the source is re-arbitrated.
  - Masking the granted source while in REQ or SERVICE does not cancel the grant.
  - A mask change takes effect at the next IDLE arbitration.
  - With NUM_SRC=1, `rr_ptr` is constant 0.
  - Asserting `sysreset` mid-operation immediately forces IDLE and clears `src_q`, `pending`, `mask`, `grant`, `rr_ptr`, `timeout` and the counter. Outputs go to `interrupt_request=0`, `irq_cause=8'h00` and `irq_pending=0`.

## Timing
- **Source edge to pending:** if `src_in` rises at cycle N, `pending` is visible at N+1.
- **Pending to request:** if the source is enabled, `interrupt_request` rises at N+2. The `nexys4_if` `interrupt` output rises at N+3.
- **Acknowledge:** if `interrupt_ack` is seen at cycle A, `interrupt_request` is still 1 during A and 0 from A+1. `nexys4_if` gives ack priority, so this does not cause a double interrupt.
- **EOI:** if the EOI strobe occurs at cycle E, the block is in IDLE at E+1. The next request can rise at E+2.
- **Timeout:** the counter starts at 0 on entry to REQ and increments each REQ cycle. The timeout exit happens on the cycle the count equals ACK_TIMEOUT, i.e. after ACK_TIMEOUT+1 cycles in REQ.
- **Register outputs:** all outputs are registered; there is no combinational path from input to output.

## Structure
- **Package `nexys4_irq_pkg`** holds:
  - the state enum (IDLE, REQ, SERVICE);
  - `EOI_PORT_BIT=4` and `MASK_PORT_BIT=5`;
  - cause-bit positions (`CAUSE_INSVC=7`, `CAUSE_TMO=6`, `CAUSE_IDX_MSB=2`).
- **Sub-module `nexys4_rr_picker`:** combinational. It takes the request vector and the pointer and returns `valid` and `index`. It is parameterised by NUM_SRC.

## Test plan
- **Single source:** mask=4'b0001, rising edge on `src_in[0]` at cycle 10 → `interrupt_request` high at cycle 12. Ack at 15 → request low at 16 and `irq_cause`=8'h80. EOI → `irq_cause`=8'h00 and `irq_pending`=0.
- **Round-robin:** mask=4'hF, all four sources edge together → grants in order 0, 1, 2, 3, each after its EOI. A second edge on src0 during service of 1 → src0 is granted after 3.
- **Masked source:** mask=0, edge on src2 → `irq_pending`=4'b0100 and no request. Then write mask=4'b0100 → request within 2 cycles and cause index 2.
- **Timeout:** ACK_TIMEOUT=8, never ack → request low after 9 REQ cycles and `irq_cause[6]`=1. The block re-requests the same source. Ack then EOI → bit6 cleared.
- **Collisions:** EOI for src1 in the same cycle as a new src1 edge → pending bit1 stays set and src1 is re-granted. EOI in IDLE or REQ → no state change.
- **Async reset:** reset asserted in SERVICE mid-cycle → `interrupt_request`=0 and `irq_cause`=0 before the next clock edge. After release, mask=0 and no request.
